// File: rtl/accum_pkg.sv
// Shared definitions for the frame accumulator: FSM state encodings and the
// operand-count width helper. Optional saturation is enabled by ACCUM_SAT_EN.
package accum_pkg;

  localparam logic [0:0] ST_ACC  = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  // Counter must hold the value NUM itself, hence the extra bit.
  function automatic int cnt_width(input int num);
    return $clog2(num) + 1;
  endfunction

endpackage

// File: rtl/fa_nbit.sv
// BIT-wide ripple adder with carry-in and carry-out, used as the accumulator datapath.
module fa_nbit #(
  parameter int BIT = 4
) (
  input  logic [BIT-1:0] a_i,
  input  logic [BIT-1:0] b_i,
  input  logic           cin_i,
  output logic [BIT-1:0] sum_o,
  output logic           cout_o
);

  logic [BIT:0] full_s;

  // Widen by one bit so the carry-out falls out of the addition.
  always_comb begin
    full_s = {1'b0, a_i} + {1'b0, b_i} + {{BIT{1'b0}}, cin_i};
    sum_o  = full_s[BIT-1:0];
    cout_o = full_s[BIT];
  end

endmodule

// File: rtl/accum_nbit.sv
// Frame accumulator: sums NUM operands, then holds the sum and sticky carry flag
// until the consumer takes it. Define ACCUM_SAT_EN to saturate instead of wrapping.
module accum_nbit
  import accum_pkg::*;
#(
  parameter int BIT = 4,
  parameter int NUM = 4
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           in_valid_i,
  output logic           in_ready_o,
  input  logic [BIT-1:0] data_i,
  output logic           out_valid_o,
  input  logic           out_ready_i,
  output logic [BIT-1:0] sum_o,
  output logic           ovf_o
);

  localparam int CW = cnt_width(NUM);

  logic [0:0]     state_r;
  logic [BIT-1:0] acc_r;
  logic           ovf_r;
  logic [CW-1:0]  cnt_r;
  logic [BIT-1:0] add_sum_s;
  logic           add_cout_s;
  logic [BIT-1:0] acc_next_s;
  logic           accept_s;
  logic           last_s;

  fa_nbit #(.BIT(BIT)) u_add (
    .a_i    (acc_r),
    .b_i    (data_i),
    .cin_i  (1'b0),
    .sum_o  (add_sum_s),
    .cout_o (add_cout_s)
  );

  // Accept qualification and next accumulator value.
  always_comb begin
    accept_s = in_valid_i & (state_r == ST_ACC);
    last_s   = (cnt_r == CW'(NUM - 1));
`ifdef ACCUM_SAT_EN
    // Once saturated, all-ones plus anything either carries or stays all-ones.
    if (add_cout_s) begin
      acc_next_s = {BIT{1'b1}};
    end else begin
      acc_next_s = add_sum_s;
    end
`else
    acc_next_s = add_sum_s;
`endif
  end

  // FSM, operand count, accumulator and sticky overflow.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= ST_ACC;
      acc_r   <= {BIT{1'b0}};
      ovf_r   <= 1'b0;
      cnt_r   <= {CW{1'b0}};
    end else begin
      case (state_r)
        ST_ACC: begin
          if (accept_s) begin
            acc_r   <= acc_next_s;
            ovf_r   <= ovf_r | add_cout_s;
            cnt_r   <= cnt_r + CW'(1);
            state_r <= last_s ? ST_HOLD : ST_ACC;
          end else begin
            state_r <= ST_ACC;
          end
        end
        ST_HOLD: begin
          if (out_ready_i) begin
            acc_r   <= {BIT{1'b0}};
            ovf_r   <= 1'b0;
            cnt_r   <= {CW{1'b0}};
            state_r <= ST_ACC;
          end else begin
            state_r <= ST_HOLD;
          end
        end
        default: begin
          state_r <= ST_ACC;
        end
      endcase
    end
  end

  // Outputs decode directly from registered state; result lines are zero while accumulating.
  always_comb begin
    in_ready_o  = (state_r == ST_ACC);
    out_valid_o = (state_r == ST_HOLD);
    if (state_r == ST_HOLD) begin
      sum_o = acc_r;
      ovf_o = ovf_r;
    end else begin
      sum_o = {BIT{1'b0}};
      ovf_o = 1'b0;
    end
  end

endmodule

// File: doc/accum_nbit.md
ACCUM_NBIT -- requirements
Module: accum_nbit

Interface
REQ-001 SHALL have parameter BIT, default 4, giving the operand and sum width (minimum 1).
REQ-002 SHALL have parameter NUM, default 4, giving the operands per frame (minimum 1).
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port in_valid_i, input, 1 bit: the operand on data_i is valid.
REQ-006 SHALL have port in_ready_o, output, 1 bit: the block can accept an operand.
REQ-007 SHALL have port data_i, input, BIT bits: the operand; don't-care when not valid.
REQ-008 SHALL have port out_valid_o, output, 1 bit: the frame result is presented.
REQ-009 SHALL have port out_ready_i, input, 1 bit: the consumer takes the result.
REQ-010 SHALL have port sum_o, output, BIT bits: the accumulated frame sum.
REQ-011 SHALL have port ovf_o, output, 1 bit: sticky carry-out flag for the frame.

Function
REQ-012 SHALL implement a two-state FSM with states ACC and HOLD.
REQ-013 In ACC, SHALL drive in_ready_o=1 and out_valid_o=0.
REQ-014 An operand SHALL be accepted only on a rising edge with in_valid_i & in_ready_o; the accumulator SHALL then update to acc + data_i (carry-in 0), and the count SHALL increment.
REQ-015 On every accept, ovf SHALL be ORed with the adder carry-out, making it sticky for the frame.
REQ-016 When the accepted operand is the NUM-th of the frame, the next state SHALL be HOLD.
REQ-017 In HOLD, SHALL drive out_valid_o=1, in_ready_o=0, sum_o=acc and ovf_o=ovf; in_valid_i SHALL be ignored.
REQ-018 Latency SHALL be 1: out_valid_o rises the cycle after the NUM-th accept.
REQ-019 In HOLD with out_ready_i=1 on a rising edge, SHALL clear acc, ovf and the count, and return to ACC; no operand is accepted in that cycle (one-cycle bubble).
REQ-020 While out_ready_i=0 in HOLD, sum_o and ovf_o SHALL stay stable.
REQ-021 Without the saturation feature, acc SHALL wrap modulo 2^BIT.
REQ-022 Gaps in in_valid_i SHALL neither count nor alter acc.
REQ-023 With NUM=1, every accept SHALL go directly to HOLD.
REQ-024 The count SHALL be $clog2(NUM)+1 bits wide and never exceed NUM.
REQ-025 sum_o and ovf_o SHALL read 0 in ACC.

Reset
REQ-026 rst_i=1 SHALL, on the next edge, force state ACC, acc=0, ovf=0 and count=0; out_valid_o=0, in_ready_o=1, sum_o=0 and ovf_o=0.
REQ-027 Reset mid-frame or during HOLD SHALL discard the partial or held result; rst_i SHALL take priority over all handshakes.

Configuration
REQ-028 Macro ACCUM_SAT_EN defined: on any carry-out, acc SHALL become all-ones and stay there for the rest of the frame, and ovf SHALL be set.
REQ-029 Macro ACCUM_SAT_EN undefined: wrap behaviour per REQ-021; there SHALL be no saturation logic.

Structure
REQ-030 Package accum_pkg SHALL hold the state encodings ST_ACC and ST_HOLD and the count-width constant function.
REQ-031 The adder SHALL be one instance of sub-module fa_nbit (BIT passed through, cin_i tied 0, cout_o feeding ovf/saturation); accum_nbit SHALL hold only the FSM, count and registers.

Verification (BIT=4, NUM=4 unless noted)
REQ-032 Send 1,2,3,4 back-to-back -> out_valid_o=1 the cycle after the 4th accept; sum_o=A, ovf_o=0.
REQ-033 Send F,1,0,0 -> sum_o=0, ovf_o=1; with ACCUM_SAT_EN defined -> sum_o=F, ovf_o=1.
REQ-034 Hold out_ready_i=0 for 5 cycles in HOLD while pulsing in_valid_i -> sum_o/ovf_o stable, in_ready_o=0, nothing accepted; then out_ready_i=1 -> ACC with acc=0.
REQ-035 Send 2,2,2,2 with in_valid_i toggling each cycle -> only valid cycles count; sum_o=8.
REQ-036 Accept 7,7, assert rst_i one cycle, then send 1,1,1,1 -> sum_o=4, ovf_o=0.
REQ-037 With NUM=1, send 9 -> HOLD next cycle with sum_o=9.
